// File: rtl/bus_arbiter_mux_pkg.sv
// bus_arbiter_pkg: shared definitions for the bus arbiter/mux slice.
//   - default WIDTH / NSRC / CNTW values
//   - source-index enum matching the legacy DataBus gate order
//   - popcount helper used for multi-driver detection (up to 32 sources)
package bus_arbiter_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_NSRC  = 4;
    localparam int DEF_CNTW  = 8;

    // Legacy gate order; the lowest index has the highest fixed priority.
    typedef enum logic [1:0] {
        SRC_PC     = 2'd0,
        SRC_MDR    = 2'd1,
        SRC_ALU    = 2'd2,
        SRC_MARMUX = 2'd3
    } src_e;

    function automatic int unsigned popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n += {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/bus_arbiter_mux_if.sv
// bus_arbiter_mux_if: groups the source side (Data, Sel, ClrErr) and the
// bus/status side (DataBus, Grant, Conflict, ConflictCnt, ConflictMask).
//   master modport: the sequencer/datapath that drives Sel/Data/ClrErr.
//   slave  modport: the arbiter/mux itself.
// Request semantics: Sel[i] is a level request held by source i for as long as
// it wants the bus; Grant is the same-cycle one-hot answer. There is no
// back-pressure: a request that is not granted simply loses that cycle.
interface bus_arbiter_mux_if
    import bus_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NSRC  = DEF_NSRC,
    parameter int CNTW  = DEF_CNTW
) ();

    logic [NSRC*WIDTH-1:0] Data;
    logic [NSRC-1:0]       Sel;
    logic                  ClrErr;
    logic [WIDTH-1:0]      DataBus;
    logic [NSRC-1:0]       Grant;
    logic                  Conflict;
    logic [CNTW-1:0]       ConflictCnt;
    logic [NSRC-1:0]       ConflictMask;

    modport master (
        output Data, Sel, ClrErr,
        input  DataBus, Grant, Conflict, ConflictCnt, ConflictMask
    );

    modport slave (
        input  Data, Sel, ClrErr,
        output DataBus, Grant, Conflict, ConflictCnt, ConflictMask
    );

endinterface

// File: rtl/bus_arbiter_mux_rr_pick.sv
// rr_pick: rotate / find-first-set arbiter core.
//   req    : request vector
//   ptr    : index where the search starts (wraps modulo NSRC)
//   grant  : one-hot winner, all zero when no request
//   winner : binary index of the winner (0 when no request)
//   valid  : any request present
// With ptr tied to 0 this degenerates to fixed lowest-index priority.
module rr_pick
    import bus_arbiter_pkg::*;
#(
    parameter int NSRC = DEF_NSRC,
    parameter int PW   = (NSRC > 1) ? $clog2(NSRC) : 1
) (
    input  logic [NSRC-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NSRC-1:0] grant,
    output logic [PW-1:0]   winner,
    output logic            valid
);

    logic [2*NSRC-1:0] dbl;
    logic [NSRC-1:0]   rot;

    always_comb begin
        // Rotate right by ptr so bit 0 of rot is the search start.
        dbl    = {req, req} >> ptr;
        rot    = dbl[NSRC-1:0];
        grant  = '0;
        winner = '0;
        valid  = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (!valid && rot[i]) begin
                valid  = 1'b1;
                winner = (int'(ptr) + i >= NSRC) ? PW'(int'(ptr) + i - NSRC)
                                                 : PW'(int'(ptr) + i);
            end
        end
        if (valid) begin
            grant = NSRC'(1) << winner;
        end
    end

endmodule

// File: rtl/bus_arbiter_mux.sv
// bus_arbiter_mux: arbitrated shared-bus gate mux.
//   Clk, Reset_n : clock (rising edge), asynchronous active-low reset
//   bus (slave)  : Data/Sel/ClrErr in; DataBus/Grant/Conflict/ConflictCnt/
//                  ConflictMask out
// Grant and DataBus are combinational. When nothing is selected the bus shows
// the last driven value (bus-hold) instead of floating. Multi-driver cycles are
// flagged one cycle later, counted (saturating) and the first offending Sel
// pattern is latched until ClrErr.
module bus_arbiter_mux
    import bus_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NSRC  = DEF_NSRC,
    parameter int RR    = 0,
    parameter int CNTW  = DEF_CNTW
) (
    input  logic               Clk,
    input  logic               Reset_n,
    bus_arbiter_mux_if.slave   bus
);

    localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;

    logic [WIDTH-1:0] hold_q, hold_d;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic             conflict_q, conflict_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [NSRC-1:0]  mask_q, mask_d;

    logic [PW-1:0]    pick_ptr;
    logic [NSRC-1:0]  grant;
    logic [PW-1:0]    winner;
    logic             any_sel;
    logic             multi;
    logic [WIDTH-1:0] mux;

    // Fixed-priority mode always searches from index 0.
    assign pick_ptr = (RR != 0) ? rr_ptr_q : '0;

    rr_pick #(.NSRC(NSRC), .PW(PW)) u_pick (
        .req    (bus.Sel),
        .ptr    (pick_ptr),
        .grant  (grant),
        .winner (winner),
        .valid  (any_sel)
    );

    assign multi = (popcount(32'(bus.Sel)) > 1);

    // AND-OR mux over the one-hot grant.
    always_comb begin
        mux = '0;
        for (int i = 0; i < NSRC; i++) begin
            mux |= bus.Data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}};
        end
    end

    // Outputs are forced to 0 while reset is asserted, without waiting for a clock.
    assign bus.Grant        = Reset_n ? grant : '0;
    assign bus.DataBus      = !Reset_n ? '0 : (any_sel ? mux : hold_q);
    assign bus.Conflict     = conflict_q;
    assign bus.ConflictCnt  = cnt_q;
    assign bus.ConflictMask = mask_q;

    always_comb begin
        hold_d     = hold_q;
        rr_ptr_d   = rr_ptr_q;
        conflict_d = multi;
        cnt_d      = cnt_q;
        mask_d     = mask_q;
        if (any_sel) begin
            hold_d = mux;
            if (RR != 0) begin
                rr_ptr_d = (winner == PW'(NSRC - 1)) ? '0 : winner + 1'b1;
            end
        end
        // ClrErr takes precedence over a same-cycle conflict.
        if (bus.ClrErr) begin
            cnt_d  = '0;
            mask_d = '0;
        end else if (multi) begin
            if (cnt_q != {CNTW{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (mask_q == '0) begin
                mask_d = bus.Sel;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hold_q     <= '0;
            rr_ptr_q   <= '0;
            conflict_q <= 1'b0;
            cnt_q      <= '0;
            mask_q     <= '0;
        end else begin
            hold_q     <= hold_d;
            rr_ptr_q   <= rr_ptr_d;
            conflict_q <= conflict_d;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
        end
    end

    // An unknown gate line means the sequencer is broken; flag it loudly.
    always @(posedge Clk) begin
        if (Reset_n) begin
            assert (!$isunknown(bus.Sel));
        end
    end

endmodule
